// File: rtl/sd_pkg.sv
// Shared constants, types and CRC7 step for the SD host CMD-line path.
package sd_pkg;

  localparam int unsigned SD_RESP_SHORT_BITS = 48;
  localparam int unsigned SD_RESP_LONG_BITS  = 136;
  localparam logic [6:0]  SD_CRC7_POLY       = 7'h09;
  localparam int unsigned SD_BIT_CNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    RECV,
    DONE
  } sd_rx_state_t;

  typedef logic [SD_BIT_CNT_W-1:0] sd_bit_cnt_t;

  // One serial CRC7 step, MSB first (x^7 + x^3 + 1).
  function automatic logic [6:0] sd_crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = crc[6] ^ din;
    return {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator; shared between the CMD transmitter and receiver.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  // Clear wins over a same-cycle update so a new frame always starts from zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (en) begin
      crc <= sd_crc7_step(crc, din);
    end
  end

endmodule

// File: rtl/sd_cmd_resp_rx.sv
// SD CMD-line response receiver: start-bit wait, frame capture, framing/CRC7 check.
module sd_cmd_resp_rx
  import sd_pkg::*;
#(
  parameter int unsigned NCR_MAX    = 64,
  parameter int unsigned LONG_BITS  = SD_RESP_LONG_BITS,
  parameter int unsigned SHORT_BITS = SD_RESP_SHORT_BITS
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 bit_en,
  input  logic                 cmd_in,
  input  logic                 arm,
  input  logic                 long_resp,
  input  logic                 check_crc,
  output logic                 busy,
  output logic                 done,
  output logic [LONG_BITS-1:0] resp,
  output logic                 err_timeout,
  output logic                 err_crc,
  output logic                 err_frame
);

  localparam int unsigned WAIT_W = $clog2(NCR_MAX + 1);
  // CRC covers frame positions CRC_HI..CRC_LO; long frames skip their 8-bit header.
  localparam int unsigned CRC_LO = 8;
  localparam int unsigned CRC_HI = LONG_BITS - 9;

  sd_rx_state_t         state_q, state_d;
  sd_bit_cnt_t          bit_cnt_q;
  sd_bit_cnt_t          frame_len;
  sd_bit_cnt_t          crc_pos;
  logic [WAIT_W-1:0]    wait_cnt_q;
  logic                 long_q;
  logic                 chk_q;
  logic                 wait_last;
  logic                 last_bit;
  logic                 clear_c;
  logic                 shift_c;
  logic                 wait_inc_c;
  logic                 timeout_c;
  logic                 finish_c;
  logic                 leave_c;
  logic                 crc_en_c;
  logic [LONG_BITS-1:0] resp_shift;
  logic [6:0]           crc;
  logic                 frame_bad;
  logic                 crc_bad;

  assign frame_len  = long_q ? sd_bit_cnt_t'(LONG_BITS) : sd_bit_cnt_t'(SHORT_BITS);
  assign last_bit   = (bit_cnt_q == frame_len - sd_bit_cnt_t'(1));
  assign wait_last  = (wait_cnt_q == WAIT_W'(NCR_MAX - 1));
  assign resp_shift = {resp[LONG_BITS-2:0], cmd_in};

  // Frame position of the bit currently being shifted in (first bit = frame_len-1).
  assign crc_pos  = frame_len - bit_cnt_q - sd_bit_cnt_t'(1);
  assign crc_en_c = shift_c && (crc_pos >= sd_bit_cnt_t'(CRC_LO))
                            && (crc_pos <= sd_bit_cnt_t'(CRC_HI));

  // Checks are evaluated on the post-shift frame so results land with the done pulse.
  assign frame_bad = (long_q ? resp_shift[LONG_BITS-2] : resp_shift[SHORT_BITS-2])
                   | ~resp_shift[0];
  assign crc_bad   = (crc != resp_shift[7:1]);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a start bit takes priority over an expiring wait counter.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (arm) state_d = WAIT_START;
      WAIT_START: if (bit_en) begin
                    if (!cmd_in)        state_d = RECV;
                    else if (wait_last) state_d = DONE;
                  end
      RECV:       if (bit_en && last_bit) state_d = DONE;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Per-state datapath controls.
  always_comb begin
    clear_c    = 1'b0;
    shift_c    = 1'b0;
    wait_inc_c = 1'b0;
    timeout_c  = 1'b0;
    finish_c   = 1'b0;
    leave_c    = 1'b0;
    case (state_q)
      IDLE:       clear_c = arm;
      WAIT_START: if (bit_en) begin
                    if (!cmd_in)        shift_c    = 1'b1;
                    else if (wait_last) timeout_c  = 1'b1;
                    else                wait_inc_c = 1'b1;
                  end
      RECV:       if (bit_en) begin
                    shift_c  = 1'b1;
                    finish_c = last_bit;
                  end
      DONE:       leave_c = 1'b1;
      default:    ;
    endcase
  end

  // Frame capture, counters and registered status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      resp        <= '0;
      err_timeout <= 1'b0;
      err_crc     <= 1'b0;
      err_frame   <= 1'b0;
      bit_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      long_q      <= 1'b0;
      chk_q       <= 1'b0;
    end else begin
      done <= timeout_c | finish_c;
      if (clear_c) begin
        long_q      <= long_resp;
        chk_q       <= check_crc;
        resp        <= '0;
        err_timeout <= 1'b0;
        err_crc     <= 1'b0;
        err_frame   <= 1'b0;
        bit_cnt_q   <= '0;
        wait_cnt_q  <= '0;
        busy        <= 1'b1;
      end
      if (shift_c) begin
        resp      <= resp_shift;
        bit_cnt_q <= bit_cnt_q + sd_bit_cnt_t'(1);
      end
      if (wait_inc_c) begin
        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      end
      if (timeout_c) begin
        err_timeout <= 1'b1;
      end
      if (finish_c) begin
        err_frame <= frame_bad;
        err_crc   <= chk_q & crc_bad;
      end
      if (leave_c) begin
        busy <= 1'b0;
      end
    end
  end

  sd_crc7 u_crc7 (
    .clk    (clk),
    .resetn (resetn),
    .clear  (clear_c),
    .en     (crc_en_c),
    .din    (cmd_in),
    .crc    (crc)
  );

endmodule

// File: tb/tb_sd_cmd_resp_rx.sv
// Directed bench for sd_cmd_resp_rx.
module tb_sd_cmd_resp_rx;

  localparam logic [135:0] R7     = 136'h08000001AA13;
  localparam logic [135:0] R7_BAD = 136'h08000001AA15;
  localparam logic [135:0] R3     = 136'h3F00FF8000FF;
  localparam logic [135:0] R2     = 136'h3F_0000_0000_0000_0000_0000_0800_0001_AA13;

  logic         clk;
  logic         resetn;
  logic         bit_en;
  logic         cmd_in;
  logic         arm;
  logic         long_resp;
  logic         check_crc;
  logic         busy;
  logic         done;
  logic [135:0] resp;
  logic         err_timeout;
  logic         err_crc;
  logic         err_frame;

  int n_assert;
  int n_fail;
  int done_cnt;
  int done_base;

  sd_cmd_resp_rx dut (
    .clk         (clk),
    .resetn      (resetn),
    .bit_en      (bit_en),
    .cmd_in      (cmd_in),
    .arm         (arm),
    .long_resp   (long_resp),
    .check_crc   (check_crc),
    .busy        (busy),
    .done        (done),
    .resp        (resp),
    .err_timeout (err_timeout),
    .err_crc     (err_crc),
    .err_frame   (err_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // done is a one-cycle pulse, so each pulse spans exactly one falling edge.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // One clock: drive at the falling edge, sample 1 ns after the rising edge.
  task automatic tick(input logic en, input logic v, input logic a);
    @(negedge clk);
    bit_en = en;
    cmd_in = v;
    arm    = a;
    @(posedge clk);
    #1;
  endtask

  // Send f[n-1:0] MSB first, one idle clock between strobes, none after the last.
  task automatic send_bits(input logic [135:0] f, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      tick(1'b1, f[i], 1'b0);
      if (i != 0) tick(1'b0, f[i], 1'b0);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_errs(input string tag, input logic t, input logic c, input logic f);
    check_bit({tag, ".err_timeout"}, err_timeout, t);
    check_bit({tag, ".err_crc"},     err_crc,     c);
    check_bit({tag, ".err_frame"},   err_frame,   f);
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    done_cnt  = 0;
    done_base = 0;
    resetn    = 1'b0;
    bit_en    = 1'b0;
    cmd_in    = 1'b1;
    arm       = 1'b0;
    long_resp = 1'b0;
    check_crc = 1'b0;

    // Reset state.
    repeat (3) tick(1'b0, 1'b1, 1'b0);
    check_bit("rst.busy", busy, 1'b0);
    check_bit("rst.done", done, 1'b0);
    check_vec("rst.resp", resp, 136'h0);
    check_errs("rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    tick(1'b0, 1'b1, 1'b0);

    // cmd_in activity while idle is ignored.
    for (int i = 0; i < 8; i++) tick(1'b1, i[0], 1'b0);
    check_bit("idle.busy", busy, 1'b0);
    check_vec("idle.resp", resp, 136'h0);
    check_int("idle.done_cnt", done_cnt, 0);

    // R7 with 10 idle strobes before the start bit.
    long_resp = 1'b0;
    check_crc = 1'b1;
    done_base = done_cnt;
    tick(1'b0, 1'b1, 1'b1);
    check_bit("r7.busy_arm", busy, 1'b1);
    repeat (10) begin
      tick(1'b1, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
    end
    check_bit("r7.busy_wait", busy, 1'b1);
    check_bit("r7.done_wait", done, 1'b0);
    send_bits(R7, 48);
    check_bit("r7.done", done, 1'b1);
    check_bit("r7.busy_done", busy, 1'b1);
    check_vec("r7.resp", resp, R7);
    check_errs("r7", 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check_bit("r7.done_pulse", done, 1'b0);
    check_bit("r7.busy_after", busy, 1'b0);
    check_int("r7.done_cnt", done_cnt - done_base, 1);
    repeat (4) tick(1'b1, 1'b0, 1'b0);
    check_vec("r7.resp_hold", resp, R7);
    check_bit("r7.idle_busy", busy, 1'b0);

    // R7 with a corrupted CRC byte.
    tick(1'b0, 1'b1, 1'b1);
    send_bits(R7_BAD, 48);
    check_bit("r7bad.done", done, 1'b1);
    check_vec("r7bad.resp", resp, R7_BAD);
    check_errs("r7bad", 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);

    // R3 with CRC checking off, then on.
    check_crc = 1'b0;
    tick(1'b0, 1'b1, 1'b1);
    send_bits(R3, 48);
    check_bit("r3.done", done, 1'b1);
    check_vec("r3.resp", resp, R3);
    check_errs("r3", 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check_crc = 1'b1;
    tick(1'b0, 1'b1, 1'b1);
    send_bits(R3, 48);
    check_bit("r3chk.done", done, 1'b1);
    check_errs("r3chk", 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);

    // R2 long frame; must not finish at the short-frame length.
    long_resp = 1'b1;
    tick(1'b0, 1'b1, 1'b1);
    send_bits(R2 >> 88, 48);
    check_bit("r2.done_at48", done, 1'b0);
    check_bit("r2.busy_at48", busy, 1'b1);
    send_bits(R2, 88);
    check_bit("r2.done", done, 1'b1);
    check_vec("r2.resp", resp, R2);
    check_errs("r2", 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);

    // Timeout after NCR_MAX strobes of idle line.
    long_resp = 1'b0;
    tick(1'b0, 1'b1, 1'b1);
    repeat (63) tick(1'b1, 1'b1, 1'b0);
    check_bit("tmo.done_63", done, 1'b0);
    check_bit("tmo.busy_63", busy, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    check_bit("tmo.done_64", done, 1'b1);
    check_vec("tmo.resp", resp, 136'h0);
    check_errs("tmo", 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check_bit("tmo.busy_after", busy, 1'b0);

    // Start bit on the 64th strobe wins over the timeout.
    tick(1'b0, 1'b1, 1'b1);
    repeat (63) tick(1'b1, 1'b1, 1'b0);
    send_bits(R7, 48);
    check_bit("late.done", done, 1'b1);
    check_vec("late.resp", resp, R7);
    check_errs("late", 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);

    // Reset in the middle of a frame.
    done_base = done_cnt;
    tick(1'b0, 1'b1, 1'b1);
    send_bits(R7 >> 28, 20);
    check_bit("rstmid.busy_before", busy, 1'b1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check_bit("rstmid.busy", busy, 1'b0);
    check_bit("rstmid.done", done, 1'b0);
    check_vec("rstmid.resp", resp, 136'h0);
    check_errs("rstmid", 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (60) tick(1'b1, 1'b1, 1'b0);
    check_int("rstmid.no_done", done_cnt - done_base, 0);
    check_bit("rstmid.busy_idle", busy, 1'b0);

    // A second arm during RECV is ignored; original mode and CRC enable persist.
    long_resp = 1'b0;
    check_crc = 1'b1;
    tick(1'b0, 1'b1, 1'b1);
    long_resp = 1'b1;
    check_crc = 1'b0;
    send_bits(R7_BAD >> 28, 20);
    tick(1'b0, 1'b1, 1'b1);
    send_bits(R7_BAD, 28);
    check_bit("rearm.done", done, 1'b1);
    check_vec("rearm.resp", resp, R7_BAD);
    check_errs("rearm", 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check_bit("rearm.busy_after", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
